inst_issue: RTL

- Upstream feeder of the per-core instruction daisy chain.
- Buffers host-written instruction words in a FIFO and issues them onto the chain through a valid/ready handshake.
- Tracks a busy bit per target core, so no word reaches a core between its run word and its done pulse. This prevents a running core's local instruction registers from being overwritten.

---
 rtl/inst_pkg.sv | 20 ++
 rtl/inst_issue_if.sv | 29 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/inst_issue.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/inst_pkg.sv
// Shared field layout and issue FSM encoding for the instruction issue stage.
package inst_pkg;

  localparam int unsigned RUN_BIT  = 35;
  localparam int unsigned ID_MSB   = 34;
  localparam int unsigned ID_LSB   = 33;
  localparam int unsigned ADDR_MSB = 32;
  localparam int unsigned ADDR_LSB = 31;
  localparam int unsigned RSV_BIT  = 30;

  localparam int unsigned ID_W   = 2;
  localparam int unsigned ADDR_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StStall
  } issue_state_e;

endpackage

// File: rtl/inst_issue_if.sv
// Host-side and chain-side valid/ready handshakes of the instruction issue stage.
interface inst_issue_if #(
  parameter int unsigned IW = 36
);
  logic [IW-1:0] host_data;
  logic          host_valid;
  logic          host_ready;
  logic [IW-1:0] inst_data;
  logic          inst_valid;
  logic          inst_ready;

  modport master (
    output host_data,
    output host_valid,
    input  host_ready,
    input  inst_data,
    input  inst_valid,
    output inst_ready
  );

  modport slave (
    input  host_data,
    input  host_valid,
    output host_ready,
    output inst_data,
    output inst_valid,
    input  inst_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;

endmodule

// File: rtl/inst_issue.sv
// Instruction issue stage: host FIFO feeding the core daisy chain, in order, gated per core busy.
// Define INST_ISSUE_TIMEOUT_EN to add a stall watchdog that force-frees a stuck core.
module inst_issue
  import inst_pkg::*;
#(
  parameter int unsigned IW      = 36,
  parameter int unsigned IRW     = 30,
  parameter int unsigned IN      = 3,
  parameter int unsigned NT      = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  inst_issue_if.slave            bus,
  input  logic [NT-1:0]          done,
  output logic [NT-1:0]          busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   addr_err,
  output logic                   timeout_err
);
  localparam int unsigned NID   = 2 ** ID_W;
  localparam int unsigned NADDR = 2 ** ADDR_W;

  if ((DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0 || RSV_BIT != IRW) begin : g_bad_param
    $error("inst_issue: DEPTH must be a power of 2, TIMEOUT nonzero, IRW match the word layout");
  end

  issue_state_e state_q, state_d;

  logic [IW-1:0]     head, issue_word, out_data_q;
  logic              out_valid_q, fifo_full, fifo_empty;
  logic              ld_ok, pop, issue, drop_addr, addr_err_q;
  logic              head_run, head_busy, tmo_hit;
  logic [ID_W-1:0]   head_id;
  logic [ADDR_W-1:0] head_addr;
  logic [NID-1:0]    id_ok, busy_ext, set_mask, clr_mask;
  logic [NADDR-1:0]  addr_ok;
  logic [NT-1:0]     busy_q, busy_d;

  sync_fifo #(
    .WIDTH (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.host_valid && bus.host_ready),
    .pop   (pop),
    .wdata (bus.host_data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bus.host_ready = !fifo_full && !rst;

  for (genvar i = 0; i < NID; i++) begin : g_id_ok
    assign id_ok[i] = (i < NT);
  end
  for (genvar i = 0; i < NADDR; i++) begin : g_addr_ok
    assign addr_ok[i] = (i < IN);
  end

  assign head_run   = head[RUN_BIT];
  assign head_id    = head[ID_MSB:ID_LSB];
  assign head_addr  = head[ADDR_MSB:ADDR_LSB];
  assign busy_ext   = NID'(busy_q);
  assign head_busy  = busy_ext[head_id];
  assign issue_word = head & ~(IW'(1) << RSV_BIT);
  // Output slot is free when empty or being consumed this cycle.
  assign ld_ok      = !out_valid_q || bus.inst_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StIssue;
      StIssue: begin
        if (!fifo_empty && id_ok[head_id] && head_busy) state_d = StStall;
        else if (fifo_empty && ld_ok)                   state_d = StIdle;
      end
      StStall: if (!head_busy || tmo_hit) state_d = StIssue;
      default: state_d = StIdle;
    endcase
  end

  // Head disposition: drop bad ids, wait on busy cores, drop bad config addrs, else issue.
  always_comb begin
    pop       = 1'b0;
    issue     = 1'b0;
    drop_addr = 1'b0;
    if (state_q == StIssue && !fifo_empty) begin
      if (!id_ok[head_id]) begin
        pop = 1'b1;
      end else if (!head_busy) begin
        if (!head_run && !addr_ok[head_addr]) begin
          pop       = 1'b1;
          drop_addr = 1'b1;
        end else if (ld_ok) begin
          pop   = 1'b1;
          issue = 1'b1;
        end
      end
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue && head_run) set_mask[head_id] = 1'b1;
    if (tmo_hit)           clr_mask[head_id] = 1'b1;
    // A run loaded in the same cycle as that core's done leaves it busy.
    busy_d = (busy_q & ~done & ~clr_mask[NT-1:0]) | set_mask[NT-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      if (ld_ok) begin
        out_valid_q <= issue;
        if (issue) out_data_q <= issue_word;
      end
      busy_q     <= busy_d;
      addr_err_q <= drop_addr;
    end
  end

`ifdef INST_ISSUE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_err_q;

  assign tmo_hit = (state_q == StStall) && (tmo_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= tmo_hit;
      if (state_q == StStall && state_d == StStall) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      else                                          tmo_cnt_q <= '0;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign bus.inst_valid = out_valid_q;
  assign bus.inst_data  = out_data_q;
  assign busy           = busy_q;
  assign addr_err       = addr_err_q;

endmodule
